// File: rtl/elevator_car_fsm.sv
// Single-car elevator controller: owns car position, travel direction, door
// timing and collective up/down call servicing with capacity-aware skipping.
//
// Handshake: serve_up/serve_down/serve_car are one-cycle, one-hot "clear"
// strobes. Each is registered and asserted only on the first cycle of a door
// opening. The call owner drops the matching call bit in response. Call inputs
// are levels and are re-sampled every cycle, so a call raised at any time is
// never lost. The FSM state is visible on idle/moving/door_open, exactly one
// of which is high.
module elevator_car_fsm #(
  parameter  int NUM_FLOORS   = 7,
  parameter  int CAPACITY     = 2,
  parameter  int MOVE_CYCLES  = 4,
  parameter  int DWELL_CYCLES = 3,
  localparam int FW           = $clog2(NUM_FLOORS + 1),
  localparam int CW           = $clog2(CAPACITY + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] up_call,
  input  logic [NUM_FLOORS-1:0] down_call,
  input  logic [NUM_FLOORS-1:0] car_call,
  input  logic [CW-1:0]         occupancy,
  output logic [FW-1:0]         curr_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  idle,
  output logic [NUM_FLOORS-1:0] serve_up,
  output logic [NUM_FLOORS-1:0] serve_down,
  output logic [NUM_FLOORS-1:0] serve_car
);

  localparam int CNT_MAX = (MOVE_CYCLES > DWELL_CYCLES) ? MOVE_CYCLES : DWELL_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam logic [CNTW-1:0] MOVE_LOAD  = CNTW'(MOVE_CYCLES - 1);
  localparam logic [CNTW-1:0] DWELL_LOAD = CNTW'(DWELL_CYCLES - 1);
  localparam logic [FW-1:0]   TOP        = FW'(NUM_FLOORS);
  localparam logic [FW-1:0]   BOTTOM     = FW'(1);
  localparam logic [CW-1:0]   CAP        = CW'(CAPACITY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [FW-1:0]         floor_q, floor_d;
  logic                  dir_q, dir_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [NUM_FLOORS-1:0] su_q, su_d, sd_q, sd_d, sc_q, sc_d;

  // Per-floor masks: the floor itself, floors strictly above, strictly below.
  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = ((i + 1) == int'(f));
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = ((i + 1) > int'(f));
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = ((i + 1) < int'(f));
    return m;
  endfunction

  logic [NUM_FLOORS-1:0] any_call, here_m, next_m, rev_hall;
  logic [FW-1:0]         next_floor;
  logic                  full, ahead_here, behind_here, ahead_next, next_at_end;
  logic                  car_next, up_next, dn_next, match_next, opp_next;
  logic                  serve_match, serve_opp, stop_next;

  // Call geometry around the current floor and around the floor the car is
  // about to reach; the arrival stop decision is made on the new floor.
  always_comb begin
    any_call    = up_call | down_call | car_call;
    full        = (occupancy >= CAP) && (|car_call);
    here_m      = floor_mask(floor_q);
    ahead_here  = |(any_call & (dir_q ? above_mask(floor_q) : below_mask(floor_q)));
    behind_here = |(any_call & (dir_q ? below_mask(floor_q) : above_mask(floor_q)));
    if (dir_q) next_floor = (floor_q == TOP) ? floor_q : floor_q + FW'(1);
    else       next_floor = (floor_q == BOTTOM) ? floor_q : floor_q - FW'(1);
    next_at_end = dir_q ? (next_floor == TOP) : (next_floor == BOTTOM);
    next_m      = floor_mask(next_floor);
    ahead_next  = |(any_call & (dir_q ? above_mask(next_floor) : below_mask(next_floor)));
    car_next    = |(car_call & next_m);
    up_next     = |(up_call & next_m);
    dn_next     = |(down_call & next_m);
    match_next  = dir_q ? up_next : dn_next;
    opp_next    = dir_q ? dn_next : up_next;
    // A full car ignores hall calls. An opposite-direction hall call only
    // stops the car when nothing lies further ahead (it is the turnaround).
    serve_match = !full && match_next;
    serve_opp   = !full && !match_next && opp_next && !ahead_next;
    stop_next   = car_next || serve_match || serve_opp;
  end

  // Next-state, counter and serve-strobe logic.
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    su_d     = '0;
    sd_d     = '0;
    sc_d     = '0;
    rev_hall = '0;
    case (state_q)
      S_IDLE: begin
        if (|(any_call & here_m)) begin
          state_d = S_DOOR;
          cnt_d   = DWELL_LOAD;
          dir_d   = |((up_call | car_call) & here_m);
          sc_d    = car_call & here_m;
          if (|((up_call | car_call) & here_m)) su_d = up_call & here_m;
          else                                  sd_d = down_call & here_m;
        end else if (|(any_call & above_mask(floor_q))) begin
          state_d = S_MOVE;
          cnt_d   = MOVE_LOAD;
          dir_d   = 1'b1;
        end else if (|(any_call & below_mask(floor_q))) begin
          state_d = S_MOVE;
          cnt_d   = MOVE_LOAD;
          dir_d   = 1'b0;
        end
      end
      S_MOVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          floor_d = next_floor;
          if (stop_next) begin
            state_d = S_DOOR;
            cnt_d   = DWELL_LOAD;
            sc_d    = car_call & next_m;
            if ((dir_q && serve_match) || (!dir_q && serve_opp)) su_d = up_call & next_m;
            if ((!dir_q && serve_match) || (dir_q && serve_opp)) sd_d = down_call & next_m;
          end else if (next_at_end) begin
            // Nothing to do at the last floor (e.g. skipped hall call while
            // full): park and let IDLE re-evaluate.
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = MOVE_LOAD;
          end
        end
      end
      S_DOOR: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else if (ahead_here) begin
          state_d = S_MOVE;
          cnt_d   = MOVE_LOAD;
        end else if (behind_here) begin
          dir_d    = !dir_q;
          rev_hall = (dir_q ? down_call : up_call) & here_m;
          if (|rev_hall) begin
            state_d = S_DOOR;
            cnt_d   = DWELL_LOAD;
            sc_d    = car_call & here_m;
            if (dir_q) sd_d = rev_hall;
            else       su_d = rev_hall;
          end else begin
            state_d = S_MOVE;
            cnt_d   = MOVE_LOAD;
          end
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset; reset parks the car at
  // floor 1 immediately, even mid-move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      floor_q <= BOTTOM;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
      su_q    <= '0;
      sd_q    <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      su_q    <= su_d;
      sd_q    <= sd_d;
      sc_q    <= sc_d;
    end
  end

  assign curr_floor = floor_q;
  assign dir_up     = dir_q;
  assign moving     = (state_q == S_MOVE);
  assign door_open  = (state_q == S_DOOR);
  assign idle       = (state_q == S_IDLE);
  assign serve_up   = su_q;
  assign serve_down = sd_q;
  assign serve_car  = sc_q;

endmodule
